npc_sequencer: RTL

Fetch-stage next-PC sequencer of the five-stage MIPS pipeline. Consumes the 2-bit sign classification produced by the D-stage branch judge together with the decoded branch/jump opcode, decides whether the branch is taken, computes the target, and owns the F-stage PC register. Handles the instruction-memory ready handshake by parking a pending redirect when fetch is busy, and holds D until the redirect lands.

---
 rtl/npc_sequencer_pkg.sv | 26 ++
 rtl/npc_sequencer_br_cond.sv | 34 +++
 rtl/npc_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/npc_sequencer_pkg.sv
// Shared encodings for the fetch-stage next-PC sequencer.
// Branch op codes, judge classes, reset PC and FSM states.
package npc_sequencer_pkg;

  localparam logic [2:0] OP_BLEZ = 3'b000;
  localparam logic [2:0] OP_BGTZ = 3'b001;
  localparam logic [2:0] OP_BLTZ = 3'b010;
  localparam logic [2:0] OP_BGEZ = 3'b011;
  localparam logic [2:0] OP_J    = 3'b100;
  localparam logic [2:0] OP_JR   = 3'b101;

  localparam logic [1:0] JUDGE_ZERO = 2'b00;
  localparam logic [1:0] JUDGE_POS  = 2'b01;
  localparam logic [1:0] JUDGE_NEG  = 2'b10;
  localparam logic [1:0] JUDGE_INV  = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_PEND = 1'b1;

  function automatic logic is_cond_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/npc_sequencer_br_cond.sv
// Branch condition decode: op + judge class -> taken condition.
// Purely combinational; flags conditional ops with an invalid judge.
module npc_sequencer_br_cond
  import npc_sequencer_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic [1:0] judge,
  output logic       cond,
  output logic       invalid
);

  logic zero, pos, neg;

  assign zero = (judge == JUDGE_ZERO);
  assign pos  = (judge == JUDGE_POS);
  assign neg  = (judge == JUDGE_NEG);

  assign invalid = is_cond_op(br_op) &&
                   (judge == JUDGE_INV);

  always_comb begin
    cond = 1'b0;
    unique case (1'b1)
      (br_op == OP_BLEZ): cond = zero | neg;
      (br_op == OP_BGTZ): cond = pos;
      (br_op == OP_BLTZ): cond = neg;
      (br_op == OP_BGEZ): cond = zero | pos;
      (br_op == OP_J):    cond = 1'b1;
      (br_op == OP_JR):   cond = 1'b1;
      default:            cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_sequencer.sv
// Fetch-stage next-PC sequencer owning the F-stage PC register.
// Define DELAY_SLOT_EN to keep the delay-slot instruction (flush_f=0).
module npc_sequencer
  import npc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic [1:0]       BRJudge,
  input  logic [31:0]      pc_d,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      rs_val,
  output logic [31:0]      pc_f,
  output logic             taken,
  output logic             flush_f,
  output logic             hold_d,
  output logic             bad_judge,
  output logic [CNT_W-1:0] taken_cnt
);

  logic        state;
  logic [31:0] tgt_q;
  logic [31:0] target;
  logic [31:0] br_off;
  logic        cond;
  logic        invalid;
  logic        eval;

  npc_sequencer_br_cond u_cond (
    .br_op   (br_op),
    .judge   (BRJudge),
    .cond    (cond),
    .invalid (invalid)
  );

  assign eval   = br_valid & ~stall & (state == ST_RUN);
  assign taken  = eval & cond;
  assign hold_d = (state == ST_PEND);
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = pc_d + 32'd4 + br_off;
    unique case (1'b1)
      (br_op == OP_J):  target = {pc_d[31:28], instr_index, 2'b00};
      (br_op == OP_JR): target = rs_val;
      default:          target = pc_d + 32'd4 + br_off;
    endcase
  end

`ifdef DELAY_SLOT_EN
  assign flush_f = 1'b0;
`else
  assign flush_f = taken | (hold_d & fetch_ready);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc_f      <= RESET_PC;
      tgt_q     <= '0;
      bad_judge <= 1'b0;
      taken_cnt <= '0;
    end else begin
      if (eval & invalid)
        bad_judge <= 1'b1;
      if (state == ST_PEND) begin
        if (fetch_ready) begin
          pc_f      <= tgt_q;
          taken_cnt <= taken_cnt + 1'b1;
          state     <= ST_RUN;
        end
      end else if (!stall) begin
        if (taken) begin
          if (fetch_ready) begin
            pc_f      <= target;
            taken_cnt <= taken_cnt + 1'b1;
          end else begin
            tgt_q <= target;
            state <= ST_PEND;
          end
        end else if (fetch_ready) begin
          pc_f <= pc_f + 32'd4;
        end
      end
    end
  end

endmodule
